// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller.
//
// Accepts one core load/store at a time. Each access becomes one or two
// XLEN-aligned memory beats. Stores are shifted into byte lanes with a byte
// mask. Loads are reassembled from the beats, then sign- or zero-extended.
// Each beat has a wait counter so that a memory that never answers still
// returns an error response instead of hanging the core.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*             core request (valid/ready, store flag, funct3, addr, data)
//   rsp_*             completion pulse, load result, error flag
//   mem_read/write    beat strobes, high for the whole beat
//   mem_address       XLEN/8-aligned beat address
//   mem_wdata         write beat data
//   mem_byte_enable   write beat byte mask
//   mem_rdata         read beat data
//   mem_resp          beat complete
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef logic [2*XLEN-1:0] data2_t;
    typedef logic [2*NB-1:0]   mask2_t;
    typedef enum logic [2:0] {IDLE, B0, GAP, B1, RESP} state_t;

    // Encodings that this XLEN cannot serve, including a store with funct3[2] set.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = (f3 == 3'd7) || (we && f3[2]);
        if (XLEN == 32) bad = bad || (f3[1:0] == 2'd3) || (f3 == 3'd6);
        return bad;
    endfunction

    function automatic logic is_split(input logic [OFFW-1:0] off, input logic [1:0] sz);
        return (int'(off) + (1 << sz)) > NB;
    endfunction

    // Byte mask for one beat: low half of the shifted 2*NB mask for beat0,
    // high half for beat1.
    function automatic logic [NB-1:0] beat_mask(input logic [OFFW-1:0] off,
                                                input logic [1:0] sz, input logic hi);
        mask2_t m;
        m = mask2_t'((1 << (1 << sz)) - 1);
        m = m << off;
        return hi ? m[2*NB-1:NB] : m[NB-1:0];
    endfunction

    function automatic logic [XLEN-1:0] beat_data(input logic [OFFW-1:0] off,
                                                  input logic [XLEN-1:0] wd, input logic hi);
        data2_t w;
        w = data2_t'(wd) << (8 * int'(off));
        return hi ? w[2*XLEN-1:XLEN] : w[XLEN-1:0];
    endfunction

    // Pick the accessed bytes out of {beat1, beat0} and extend them to XLEN.
    function automatic logic [XLEN-1:0] load_ext(input data2_t raw,
                                                 input logic [OFFW-1:0] off, input logic [2:0] f3);
        logic [XLEN-1:0] sh, r;
        sh = XLEN'(raw >> (8 * int'(off)));
        case (f3[1:0])
            2'd0:    r = f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'd1:    r = f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'd2:    r = f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t            state_q;
    logic [XLEN-1:0]   addr_q, wdata_q, beat0_q;
    logic [2:0]        f3_q;
    logic              we_q, split_q;
    logic [CW-1:0]     cnt_q;
    logic              req_ready_q, rsp_valid_q, rsp_err_q, mem_read_q, mem_write_q;
    logic [XLEN-1:0]   rsp_rdata_q, mem_address_q, mem_wdata_q;
    logic [NB-1:0]     mem_be_q;

    logic [OFFW-1:0]   off_q, req_off;
    logic [XLEN-1:0]   base_q, req_base;
    logic              tmo_hit;

    assign off_q    = addr_q[OFFW-1:0];
    assign req_off  = req_addr[OFFW-1:0];
    assign base_q   = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign req_base = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    // The limit is reached on the beat cycle whose increment would hit it.
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat0_q       <= '0;
            f3_q          <= '0;
            we_q          <= 1'b0;
            split_q       <= 1'b0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        f3_q        <= req_funct3;
                        we_q        <= req_we;
                        split_q     <= is_split(req_off, req_funct3[1:0]);
                        req_ready_q <= 1'b0;
                        if (is_illegal(req_we, req_funct3)) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q       <= B0;
                            cnt_q         <= '0;
                            mem_read_q    <= !req_we;
                            mem_write_q   <= req_we;
                            mem_address_q <= req_base;
                            mem_wdata_q   <= beat_data(req_off, req_wdata, 1'b0);
                            mem_be_q      <= req_we ? beat_mask(req_off, req_funct3[1:0], 1'b0) : '0;
                        end
                    end
                end
                B0, B1: begin
                    if (mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_be_q    <= '0;
                        if (state_q == B0 && !we_q) beat0_q <= mem_rdata;
                        if (state_q == B0 && split_q) begin
                            state_q <= GAP;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            if (we_q)
                                rsp_rdata_q <= '0;
                            else if (state_q == B0)
                                rsp_rdata_q <= load_ext({{XLEN{1'b0}}, mem_rdata}, off_q, f3_q);
                            else
                                rsp_rdata_q <= load_ext({mem_rdata, beat0_q}, off_q, f3_q);
                        end
                    end else if (tmo_hit) begin
                        // Abandon the access, including any beat still to come.
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_be_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    state_q       <= B1;
                    cnt_q         <= '0;
                    mem_read_q    <= !we_q;
                    mem_write_q   <= we_q;
                    mem_address_q <= base_q + XLEN'(NB);
                    mem_wdata_q   <= beat_data(off_q, wdata_q, 1'b1);
                    mem_be_q      <= we_q ? beat_mask(off_q, f3_q[1:0], 1'b1) : '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, mem_resp = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
    logic [31:0] rsp_rdata, mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed { logic err; logic [31:0] rdata; } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard consumer: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%b rdata=%h, none expected", rsp_err, rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== {mon_e.err, mon_e.rdata}) begin
                    n_fail++;
                    $display("FAIL rsp: got err=%b rdata=%h expected err=%b rdata=%h",
                             rsp_err, rsp_rdata, mon_e.err, mon_e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for IDLE, then present one request for one accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int k = 0;
        while (req_ready !== 1'b1 && k < 20) begin tick(); k++; end
        n_chk++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // Hold the current beat for 'waits' cycles, then complete it with data d.
    task automatic respond(input int waits, input logic [31:0] d);
        repeat (waits) tick();
        mem_resp = 1'b1; mem_rdata = d;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_chk++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
        end
        n_chk++;
        if ({rsp_rdata, mem_address, mem_wdata, mem_byte_enable} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", rsp_rdata, mem_address, mem_wdata, mem_byte_enable);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
        issue(1'b0, 3'd2, 32'h100, 32'h0);
        n_chk++;
        if ({mem_read, mem_write, mem_address} !== {2'b10, 32'h100}) begin
            n_fail++; $display("FAIL lw_b0: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00000100", mem_read, mem_write, mem_address);
        end
        // A request while busy must be ignored.
        req_valid = 1'b1; req_funct3 = 3'd7;
        respond(2, 32'hDEADBEEF);
        req_valid = 1'b0; req_funct3 = 3'd0;
        n_chk++;
        if ({mem_read, rsp_valid} !== 2'b01) begin
            n_fail++; $display("FAIL lw_resp: got rd=%b vld=%b expected rd=0 vld=1", mem_read, rsp_valid);
        end
        tick();
        n_chk++;
        if ({rsp_valid, req_ready, rsp_rdata} !== {2'b01, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL lw_after: got vld=%b rdy=%b rdata=%h expected vld=0 rdy=1 rdata=deadbeef", rsp_valid, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_lb_lbu();
        exp_q.push_back('{err: 1'b0, rdata: 32'hFFFFFF80});
        issue(1'b0, 3'd0, 32'h103, 32'h0);
        n_chk++;
        if (mem_address !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h expected 00000100", mem_address); end
        respond(0, 32'h80000000);
        n_chk++;
        if (mem_read !== 1'b0) begin n_fail++; $display("FAIL lb_single_beat: got rd=%b expected 0", mem_read); end
        exp_q.push_back('{err: 1'b0, rdata: 32'h00000080});
        issue(1'b0, 3'd4, 32'h103, 32'h0);
        respond(1, 32'h80000000);
    endtask

    task automatic test_sw_split();
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        issue(1'b1, 3'd2, 32'h102, 32'hAABBCCDD);
        n_chk++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata} !== {2'b01, 32'h100, 4'b1100, 32'hCCDD0000}) begin
            n_fail++; $display("FAIL sw_b0: got rd=%b wr=%b addr=%h be=%b wd=%h expected 0 1 00000100 1100 ccdd0000",
                               mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata);
        end
        respond(0, 32'h0);
        n_chk++;
        if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL sw_gap: got rd=%b wr=%b expected 00", mem_read, mem_write); end
        tick();
        n_chk++;
        if ({mem_write, mem_address, mem_byte_enable, mem_wdata} !== {1'b1, 32'h104, 4'b0011, 32'h0000AABB}) begin
            n_fail++; $display("FAIL sw_b1: got wr=%b addr=%h be=%b wd=%h expected 1 00000104 0011 0000aabb",
                               mem_write, mem_address, mem_byte_enable, mem_wdata);
        end
        respond(0, 32'h0);
    endtask

    task automatic test_lh_split();
        exp_q.push_back('{err: 1'b0, rdata: 32'hFFFF81F2});
        issue(1'b0, 3'd1, 32'h103, 32'h0);
        respond(1, 32'hF2000000);
        tick();
        n_chk++;
        if ({mem_read, mem_address} !== {1'b1, 32'h104}) begin
            n_fail++; $display("FAIL lh_b1: got rd=%b addr=%h expected rd=1 addr=00000104", mem_read, mem_address);
        end
        respond(2, 32'h00000081);
    endtask

    task automatic test_boundary();
        // Byte store in the top lane: single beat.
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        issue(1'b1, 3'd0, 32'h107, 32'h00000055);
        n_chk++;
        if ({mem_address, mem_byte_enable, mem_wdata} !== {32'h104, 4'b1000, 32'h55000000}) begin
            n_fail++; $display("FAIL sb_top: got addr=%h be=%b wd=%h expected 00000104 1000 55000000", mem_address, mem_byte_enable, mem_wdata);
        end
        respond(0, 32'h0);
        n_chk++;
        if (mem_write !== 1'b0) begin n_fail++; $display("FAIL sb_no_split: got wr=%b expected 0", mem_write); end
        // Split word that wraps the address space.
        exp_q.push_back('{err: 1'b0, rdata: 32'h77881122});
        issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0);
        n_chk++;
        if (mem_address !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_b0: got %h expected fffffffc", mem_address); end
        respond(0, 32'h11223344);
        tick();
        n_chk++;
        if ({mem_read, mem_address} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_b1: got rd=%b addr=%h expected rd=1 addr=00000000", mem_read, mem_address);
        end
        respond(0, 32'h55667788);
    endtask

    task automatic test_timeout();
        int hi_cycles = 0;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        issue(1'b0, 3'd2, 32'h200, 32'h0);
        for (int k = 0; k < 10 && mem_read === 1'b1; k++) begin hi_cycles++; tick(); end
        n_chk++;
        if (hi_cycles != 4) begin n_fail++; $display("FAIL tmo_len: got %0d cycles expected 4", hi_cycles); end
        // Response on the limit cycle wins over the timeout.
        exp_q.push_back('{err: 1'b0, rdata: 32'h12345678});
        issue(1'b0, 3'd2, 32'h200, 32'h0);
        respond(3, 32'h12345678);
        // Timeout in beat0 of a split load skips beat1.
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        issue(1'b0, 3'd1, 32'h203, 32'h0);
        repeat (4) tick();
        tick();
        n_chk++;
        if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tmo_skip_b1: got rd=%b expected 0", mem_read); end
    endtask

    task automatic test_illegal();
        logic [3:0] cases [3];
        cases[0] = {1'b0, 3'd7};  // funct3 7
        cases[1] = {1'b1, 3'd4};  // store with funct3[2]
        cases[2] = {1'b0, 3'd3};  // ld on XLEN=32
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{err: 1'b1, rdata: 32'h0});
            issue(cases[i][3], cases[i][2:0], 32'h300, 32'hFFFFFFFF);
            n_chk++;
            if ({mem_read, mem_write, rsp_valid, rsp_err} !== 4'b0011) begin
                n_fail++; $display("FAIL illegal_%0d: got rd=%b wr=%b vld=%b err=%b expected 0011", i, mem_read, mem_write, rsp_valid, rsp_err);
            end
        end
    endtask

    task automatic test_reset_b1();
        issue(1'b0, 3'd1, 32'h103, 32'h0);
        respond(0, 32'hF2000000);
        tick();
        n_chk++;
        if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rstb1_in_b1: got rd=%b expected 1", mem_read); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({mem_read, mem_write, rsp_valid, req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL rstb1_after: got rd=%b wr=%b vld=%b rdy=%b expected 0001", mem_read, mem_write, rsp_valid, req_ready);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sw_split();
        test_lh_split();
        test_boundary();
        test_timeout();
        test_illegal();
        test_reset_b1();
        repeat (4) tick();
        n_chk++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_rsp: got %0d outstanding expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT_CYCLES, 255, maximum wait per beat for mem_resp; 0 disables the timeout.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- req_valid, in, 1, core access request.
- req_ready, out, 1, request can be accepted.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RV load/store funct3.
- req_addr, in, XLEN, byte address.
- req_wdata, in, XLEN, store data, LSB-aligned.
- rsp_valid, out, 1, access complete pulse.
- rsp_rdata, out, XLEN, extended load data.
- rsp_err, out, 1, illegal funct3 or timeout.
- mem_read, out, 1, memory read strobe.
- mem_write, out, 1, memory write strobe.
- mem_address, out, XLEN, address aligned to XLEN/8.
- mem_wdata, out, XLEN, write beat data.
- mem_byte_enable, out, XLEN/8, write byte mask.
- mem_rdata, in, XLEN, read beat data.
- mem_resp, in, 1, beat complete.

Function
REQ-003 States SHALL be IDLE, B0, GAP, B1, RESP.
REQ-004 req_ready SHALL be 1 exactly when the state is IDLE; an access is accepted on req_valid && req_ready, and addr, funct3, we and wdata are captured on that edge.
REQ-005 req_valid in any state other than IDLE SHALL be ignored.
REQ-006 Access size SHALL be 2^funct3[1:0] bytes.
- Illegal cases: size 8 when XLEN=32; funct3 6 (lwu) when XLEN=32; funct3 7; store with funct3[2]=1.
- An illegal access goes IDLE->RESP with rsp_err=1, rsp_rdata=0 and no strobe.
REQ-007 Offset SHALL be addr mod XLEN/8; the access is split when offset+size > XLEN/8.
REQ-008 B0 SHALL drive mem_address = addr with the low log2(XLEN/8) bits cleared; B1 SHALL drive that value + XLEN/8, wrapping modulo 2^XLEN.
REQ-009 Write beats SHALL be formed as follows:
- mask = ((1<<size)-1) << offset over 2*XLEN/8 bits; beat0 uses the low half, beat1 the high half.
- Data = wdata << 8*offset over 2*XLEN bits, split the same way.
REQ-010 mem_read (load) or mem_write (store) SHALL be high throughout B0 and B1, and low in IDLE, GAP and RESP.
REQ-011 On mem_resp in B0: go to GAP if split, else RESP. GAP SHALL last exactly one cycle, then B1. On mem_resp in B1: go to RESP.
REQ-012 mem_rdata SHALL be latched on each responding read beat.
- Result = ({beat1, beat0} >> 8*offset), truncated to size.
- funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
REQ-013 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the state returns to IDLE; stores return rsp_rdata=0.
REQ-014 Timeout: a per-beat counter SHALL clear on entering B0/B1 and increment on each beat cycle without mem_resp.
- When the count reaches TIMEOUT_CYCLES, the state goes to RESP with rsp_err=1 and rsp_rdata=0; any remaining beat is skipped.
- mem_resp in the same cycle as the limit SHALL take priority, and the access completes normally.
REQ-015 rsp_rdata and rsp_err SHALL hold their value from RESP until the next RESP.

Reset
REQ-016 While rst=1 at a clock edge, the state SHALL become IDLE, the counter and data buffers 0, and all outputs 0 except req_ready=1.
REQ-017 Reset during B0/GAP/B1 SHALL drop both strobes on the next cycle and produce no rsp_valid for the aborted access.

Verification
REQ-018 XLEN=32 lw at 0x100, mem_resp 3 cycles after B0 entry, mem_rdata 0xDEADBEEF -> single beat, address 0x100, rsp_rdata 0xDEADBEEF, rsp_valid 1 cycle.
REQ-019 lb at 0x103, mem_rdata 0x80000000 -> rsp_rdata 0xFFFFFF80; the same with lbu -> 0x00000080.
REQ-020 sw at 0x102, wdata 0xAABBCCDD -> B0: address 0x100, byte_enable 1100, wdata 0xCCDD0000; one idle GAP cycle; B1: address 0x104, byte_enable 0011, wdata 0x0000AABB.
REQ-021 lh at 0x103, beat0 rdata 0xF2000000, beat1 rdata 0x00000081 -> rsp_rdata 0xFFFF81F2.
REQ-022 TIMEOUT_CYCLES=4, mem_resp held 0 -> mem_read high 4 cycles, then RESP with rsp_err=1; mem_resp on cycle 4 -> normal completion with rsp_err=0.
REQ-023 Two further directed scenarios:
- funct3=7 -> no strobe, rsp_err=1 on the next cycle.
- rst asserted in B1 -> strobes low next cycle, no rsp_valid, req_ready=1.
